// File: rtl/axi4_burst_pkg.sv
// Shared constants and FSM state types for the AXI4 burst memory slave.
package axi4_burst_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

endpackage

// File: rtl/axi4_burst_addr_gen.sv
// Combinational burst address step and per-beat legality for one channel.
// WRAP bursts are accepted only when AXI4_BURST_MEM_WRAP_EN is defined;
// otherwise burst type 10 is treated like the reserved encoding.
module axi4_burst_addr_gen
    import axi4_burst_pkg::*;
#(
    parameter int WW        = 61,
    parameter int NUM_WORDS = 24
) (
    input  logic [WW-1:0] cur_word,
    input  logic [WW-1:0] start_word,
    input  logic [1:0]    burst,
    input  logic [7:0]    len,
    output logic [WW-1:0] next_word,
    output logic          cur_ok,
    output logic          next_ok
);

    localparam logic [WW-1:0] LIMIT = WW'(NUM_WORDS);

    logic          burst_ok;
    logic [WW-1:0] mask;
    logic [WW-1:0] inc;
    logic [WW-1:0] wrap_word;

    // Next word per burst type; the address still steps on illegal bursts
    // but the legality flags keep every beat from touching the RAM.
    always_comb begin
        mask      = {{(WW-8){1'b0}}, len};
        inc       = cur_word + 1'b1;
        wrap_word = (start_word & ~mask) | (inc & mask);
        burst_ok  = 1'b0;
        next_word = cur_word;
        case (burst)
            BURST_FIXED: begin
                burst_ok  = 1'b1;
                next_word = cur_word;
            end
            BURST_INCR: begin
                burst_ok  = 1'b1;
                next_word = inc;
            end
            BURST_WRAP: begin
`ifdef AXI4_BURST_MEM_WRAP_EN
                burst_ok  = (len == 8'd1) || (len == 8'd3) ||
                            (len == 8'd7) || (len == 8'd15);
`else
                burst_ok  = 1'b0;
`endif
                next_word = wrap_word;
            end
            default: begin
                burst_ok  = 1'b0;
                next_word = cur_word;
            end
        endcase
        cur_ok  = burst_ok && (cur_word < LIMIT);
        next_ok = burst_ok && (next_word < LIMIT);
    end

endmodule

// File: rtl/axi4_burst_mem.sv
// AXI4 burst-capable RAM slave: one outstanding write and one outstanding
// read, channels independent. Optional macro AXI4_BURST_MEM_WRAP_EN enables
// WRAP bursts; without it WRAP answers SLVERR with no access.
module axi4_burst_mem
    import axi4_burst_pkg::*;
#(
    parameter int AWIDTH    = 64,
    parameter int DWIDTH    = 64,
    parameter int IDWIDTH   = 4,
    parameter int NUM_WORDS = 24
) (
    input  logic                  clock_axi,
    input  logic                  reset_axi,
    input  logic [IDWIDTH-1:0]    s_axi_awid,
    input  logic [AWIDTH-1:0]     s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic [1:0]            s_axi_awburst,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DWIDTH-1:0]     s_axi_wdata,
    input  logic [DWIDTH/8-1:0]   s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [IDWIDTH-1:0]    s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [IDWIDTH-1:0]    s_axi_arid,
    input  logic [AWIDTH-1:0]     s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic [1:0]            s_axi_arburst,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [IDWIDTH-1:0]    s_axi_rid,
    output logic [DWIDTH-1:0]     s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready
);

    localparam int DBYTES = DWIDTH / 8;
    localparam int BSH    = $clog2(DBYTES);
    localparam int WW     = AWIDTH - BSH;
    localparam int MW     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    logic [DWIDTH-1:0] mem [NUM_WORDS];

    // Holds both address-ready outputs low until the first edge after reset.
    logic live;

    // ---------------- write channel ----------------
    wr_state_t         w_state, w_next;
    logic [IDWIDTH-1:0] w_id;
    logic [WW-1:0]      w_word, w_start, w_nxt;
    logic [7:0]         w_len, w_beat;
    logic [1:0]         w_burst;
    logic               w_err, w_ok, w_nxt_ok;
    logic               aw_hs, w_hs, w_last_beat;
    logic [WW-1:0]      aw_word;

    assign aw_word     = s_axi_awaddr[AWIDTH-1:BSH];
    assign w_last_beat = (w_beat == w_len);
    assign aw_hs       = s_axi_awvalid && s_axi_awready;
    assign w_hs        = s_axi_wvalid && s_axi_wready;
    assign s_axi_bid   = w_id;

    axi4_burst_addr_gen #(.WW(WW), .NUM_WORDS(NUM_WORDS)) u_wr_gen (
        .cur_word   (w_word),
        .start_word (w_start),
        .burst      (w_burst),
        .len        (w_len),
        .next_word  (w_nxt),
        .cur_ok     (w_ok),
        .next_ok    (w_nxt_ok)
    );

    // Write FSM state register plus the startup enable.
    always_ff @(posedge clock_axi or posedge reset_axi) begin
        if (reset_axi) begin
            w_state <= W_IDLE;
            live    <= 1'b0;
        end else begin
            w_state <= w_next;
            live    <= 1'b1;
        end
    end

    // Write FSM next state and handshake outputs.
    always_comb begin
        w_next        = w_state;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        s_axi_bresp   = RESP_OKAY;
        case (w_state)
            W_IDLE: begin
                s_axi_awready = live;
                if (s_axi_awvalid && live) w_next = W_DATA;
            end
            W_DATA: begin
                s_axi_wready = 1'b1;
                if (s_axi_wvalid && w_last_beat) w_next = W_RESP;
            end
            W_RESP: begin
                s_axi_bvalid = 1'b1;
                s_axi_bresp  = w_err ? RESP_SLVERR : RESP_OKAY;
                if (s_axi_bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    // Write burst context: latched on AW, stepped and error-accumulated per W beat.
    always_ff @(posedge clock_axi or posedge reset_axi) begin
        if (reset_axi) begin
            w_id    <= '0;
            w_word  <= '0;
            w_start <= '0;
            w_len   <= '0;
            w_beat  <= '0;
            w_burst <= BURST_FIXED;
            w_err   <= 1'b0;
        end else if (aw_hs) begin
            w_id    <= s_axi_awid;
            w_word  <= aw_word;
            w_start <= aw_word;
            w_len   <= s_axi_awlen;
            w_beat  <= '0;
            w_burst <= s_axi_awburst;
            w_err   <= 1'b0;
        end else if (w_hs) begin
            w_word  <= w_nxt;
            w_beat  <= w_beat + 8'd1;
            w_err   <= w_err || !w_ok || (s_axi_wlast != w_last_beat);
        end
    end

    // RAM byte writes; contents deliberately survive reset.
    always_ff @(posedge clock_axi) begin
        if (w_hs && w_ok) begin
            for (int b = 0; b < DBYTES; b++) begin
                if (s_axi_wstrb[b]) mem[w_word[MW-1:0]][8*b +: 8] <= s_axi_wdata[8*b +: 8];
            end
        end
    end

    // ---------------- read channel ----------------
    rd_state_t          r_state, r_next;
    logic [IDWIDTH-1:0] r_id;
    logic [WW-1:0]      r_word, r_start, r_nxt;
    logic [WW-1:0]      g_cur, g_start, ar_word;
    logic [7:0]         r_len, r_beat, g_len;
    logic [1:0]         r_burst, g_burst, r_resp;
    logic [DWIDTH-1:0]  r_data;
    logic               r_ok, r_nxt_ok, ar_hs, r_hs, r_last;

    assign ar_word = s_axi_araddr[AWIDTH-1:BSH];
    assign ar_hs   = s_axi_arvalid && s_axi_arready;
    assign r_hs    = s_axi_rvalid && s_axi_rready;
    assign r_last  = (r_beat == r_len);

    // In idle the generator judges the incoming start address for beat 0.
    assign g_cur   = (r_state == R_IDLE) ? ar_word       : r_word;
    assign g_start = (r_state == R_IDLE) ? ar_word       : r_start;
    assign g_len   = (r_state == R_IDLE) ? s_axi_arlen   : r_len;
    assign g_burst = (r_state == R_IDLE) ? s_axi_arburst : r_burst;

    assign s_axi_rid   = r_id;
    assign s_axi_rdata = r_data;
    assign s_axi_rresp = r_resp;

    axi4_burst_addr_gen #(.WW(WW), .NUM_WORDS(NUM_WORDS)) u_rd_gen (
        .cur_word   (g_cur),
        .start_word (g_start),
        .burst      (g_burst),
        .len        (g_len),
        .next_word  (r_nxt),
        .cur_ok     (r_ok),
        .next_ok    (r_nxt_ok)
    );

    // Read FSM state register.
    always_ff @(posedge clock_axi or posedge reset_axi) begin
        if (reset_axi) r_state <= R_IDLE;
        else           r_state <= r_next;
    end

    // Read FSM next state and handshake outputs.
    always_comb begin
        r_next        = r_state;
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
        s_axi_rlast   = 1'b0;
        case (r_state)
            R_IDLE: begin
                s_axi_arready = live;
                if (s_axi_arvalid && live) r_next = R_DATA;
            end
            R_DATA: begin
                s_axi_rvalid = 1'b1;
                s_axi_rlast  = r_last;
                if (s_axi_rready && r_last) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    // Read beat register: beat 0 loads on AR, each accepted non-last beat loads the next.
    always_ff @(posedge clock_axi or posedge reset_axi) begin
        if (reset_axi) begin
            r_id    <= '0;
            r_word  <= '0;
            r_start <= '0;
            r_len   <= '0;
            r_beat  <= '0;
            r_burst <= BURST_FIXED;
            r_data  <= '0;
            r_resp  <= RESP_OKAY;
        end else if (ar_hs) begin
            r_id    <= s_axi_arid;
            r_word  <= ar_word;
            r_start <= ar_word;
            r_len   <= s_axi_arlen;
            r_beat  <= '0;
            r_burst <= s_axi_arburst;
            r_data  <= r_ok ? mem[ar_word[MW-1:0]] : '0;
            r_resp  <= r_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (r_hs && !r_last) begin
            r_word  <= r_nxt;
            r_beat  <= r_beat + 8'd1;
            r_data  <= r_nxt_ok ? mem[r_nxt[MW-1:0]] : '0;
            r_resp  <= r_nxt_ok ? RESP_OKAY : RESP_SLVERR;
        end
    end

    // Byte-offset address bits and the write look-ahead flag carry no meaning here.
    logic unused_ok;
    assign unused_ok = &{1'b0, s_axi_awaddr[BSH-1:0], s_axi_araddr[BSH-1:0], w_nxt_ok};

endmodule

// File: tb/tb_axi4_burst_mem.sv
// Scoreboard bench for axi4_burst_mem: directed bursts push expected B/R
// responses into queues; a monitor pops and compares on every handshake.
module tb_axi4_burst_mem;

    localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10, RSVD = 2'b11;
    localparam logic [1:0] OK = 2'b00, SLV = 2'b10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  awid = '0, arid = '0, bid, rid;
    logic [63:0] awaddr = '0, araddr = '0, wdata = '0, rdata;
    logic [7:0]  awlen = '0, arlen = '0, wstrb = '0;
    logic [1:0]  awburst = '0, arburst = '0, bresp, rresp;
    logic        awvalid = 0, awready, wlast = 0, wvalid = 0, wready;
    logic        bvalid, bready = 1, arvalid = 0, arready;
    logic        rlast, rvalid, rready = 1;

    always #5 clk = ~clk;

    axi4_burst_mem dut (
        .clock_axi(clk), .reset_axi(rst),
        .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
        .s_axi_awburst(awburst), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
        .s_axi_arburst(arburst), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready)
    );

    typedef struct { logic [3:0] id; logic [1:0] resp; } b_exp_t;
    typedef struct { logic [3:0] id; logic [63:0] data; logic [1:0] resp; logic last; } r_exp_t;

    b_exp_t b_q[$];
    r_exp_t r_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] wbuf [16];
    logic rd_toggle = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: handshake timed out at %0t", name, $time);
    endtask

    task automatic exp_b(input logic [3:0] id, input logic [1:0] resp);
        b_q.push_back('{id: id, resp: resp});
    endtask

    task automatic exp_r(input logic [3:0] id, input logic [63:0] d, input logic [1:0] resp, input logic last);
        r_q.push_back('{id: id, data: d, resp: resp, last: last});
    endtask

    // rready driver: toggles every cycle while a stall test is active.
    initial forever begin
        @(posedge clk);
        #1;
        rready = rd_toggle ? ~rready : 1'b1;
    end

    // Monitor: compares every B/R handshake against the queues, and checks
    // that a stalled R beat is held unchanged into the next cycle.
    initial begin
        b_exp_t be;
        r_exp_t re;
        logic hold_pend;
        logic [63:0] hold_data;
        logic hold_last;
        hold_pend = 0;
        hold_data = '0;
        hold_last = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_pend = 0;
            end else begin
                if (bvalid && bready) begin
                    if (b_q.size() == 0) begin
                        chk("b_unexpected", 64'(bvalid), 64'd0);
                    end else begin
                        be = b_q.pop_front();
                        chk("bid", 64'(bid), 64'(be.id));
                        chk("bresp", 64'(bresp), 64'(be.resp));
                    end
                end
                if (hold_pend && rvalid) begin
                    chk("r_hold_data", rdata, hold_data);
                    chk("r_hold_last", 64'(rlast), 64'(hold_last));
                end
                if (rvalid && rready) begin
                    if (r_q.size() == 0) begin
                        chk("r_unexpected", 64'(rvalid), 64'd0);
                    end else begin
                        re = r_q.pop_front();
                        chk("rid", 64'(rid), 64'(re.id));
                        chk("rdata", rdata, re.data);
                        chk("rresp", 64'(rresp), 64'(re.resp));
                        chk("rlast", 64'(rlast), 64'(re.last));
                    end
                end
                hold_pend = rvalid && !rready;
                hold_data = rdata;
                hold_last = rlast;
            end
        end
    end

    task automatic send_aw(input logic [3:0] id, input logic [63:0] a, input logic [7:0] len, input logic [1:0] bt);
        int t;
        awid = id; awaddr = a; awlen = len; awburst = bt; awvalid = 1;
        t = 0;
        do begin @(negedge clk); t++; end while (!awready && t < 50);
        if (!awready) fail_now("aw_handshake");
        @(posedge clk); #1;
        awvalid = 0;
    endtask

    task automatic send_w(input logic [63:0] d, input logic [7:0] s, input logic last);
        int t;
        wdata = d; wstrb = s; wlast = last; wvalid = 1;
        t = 0;
        do begin @(negedge clk); t++; end while (!wready && t < 50);
        if (!wready) fail_now("w_handshake");
        @(posedge clk); #1;
        wvalid = 0; wlast = 0;
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [63:0] a, input logic [7:0] len, input logic [1:0] bt);
        int t;
        arid = id; araddr = a; arlen = len; arburst = bt; arvalid = 1;
        t = 0;
        do begin @(negedge clk); t++; end while (!arready && t < 50);
        if (!arready) fail_now("ar_handshake");
        @(posedge clk); #1;
        arvalid = 0;
    endtask

    task automatic do_write(input logic [3:0] id, input logic [63:0] a, input logic [7:0] len,
                            input logic [1:0] bt, input logic [7:0] s, input logic bad_last);
        send_aw(id, a, len, bt);
        for (int i = 0; i <= int'(len); i++)
            send_w(wbuf[i], s, bad_last ? (i == 0) : (i == int'(len)));
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((b_q.size() != 0 || r_q.size() != 0) && t < 200) begin
            @(posedge clk);
            t++;
        end
        if (b_q.size() != 0 || r_q.size() != 0) fail_now("drain");
        b_q.delete();
        r_q.delete();
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_awready", 64'(awready), 0);
        chk("rst_arready", 64'(arready), 0);
        chk("rst_wready",  64'(wready), 0);
        chk("rst_bvalid",  64'(bvalid), 0);
        chk("rst_rvalid",  64'(rvalid), 0);
        chk("rst_rlast",   64'(rlast), 0);
        chk("rst_rdata",   rdata, 0);
        chk("rst_bid_rid", 64'({bid, rid}), 0);
        chk("rst_resp",    64'({bresp, rresp}), 0);
        @(negedge clk);
        rst = 0;
        @(posedge clk); #1;
        chk("post_rst_awready", 64'(awready), 1);
        chk("post_rst_arready", 64'(arready), 1);

        // INCR write then INCR read of words 0..3
        wbuf[0] = 64'h11; wbuf[1] = 64'h22; wbuf[2] = 64'h33; wbuf[3] = 64'h44;
        exp_b(4'd3, OK);
        do_write(4'd3, 64'h0, 8'd3, INCR, 8'hFF, 0);
        drain();
        exp_r(4'd5, 64'h11, OK, 0); exp_r(4'd5, 64'h22, OK, 0);
        exp_r(4'd5, 64'h33, OK, 0); exp_r(4'd5, 64'h44, OK, 1);
        send_ar(4'd5, 64'h0, 8'd3, INCR);
        drain();

        // WRAP read from word 2 of the 4-word block
`ifdef AXI4_BURST_MEM_WRAP_EN
        exp_r(4'd6, 64'h33, OK, 0); exp_r(4'd6, 64'h44, OK, 0);
        exp_r(4'd6, 64'h11, OK, 0); exp_r(4'd6, 64'h22, OK, 1);
`else
        exp_r(4'd6, 64'h0, SLV, 0); exp_r(4'd6, 64'h0, SLV, 0);
        exp_r(4'd6, 64'h0, SLV, 0); exp_r(4'd6, 64'h0, SLV, 1);
`endif
        send_ar(4'd6, 64'h10, 8'd3, WRAP);
        drain();

        // Burst running off the end of the RAM
        wbuf[0] = 64'hA5A5_A5A5_A5A5_A5A5; wbuf[1] = 64'h5A5A_5A5A_5A5A_5A5A;
        exp_b(4'd7, SLV);
        do_write(4'd7, 64'hB8, 8'd1, INCR, 8'hFF, 0);
        drain();
        exp_r(4'd8, 64'hA5A5_A5A5_A5A5_A5A5, OK, 1);
        send_ar(4'd8, 64'hB8, 8'd0, INCR);
        exp_r(4'd8, 64'h0, SLV, 1);
        send_ar(4'd8, 64'hC0, 8'd0, INCR);
        drain();

        // Partial strobe over a zeroed word
        wbuf[0] = 64'h0;
        exp_b(4'd1, OK);
        do_write(4'd1, 64'h0, 8'd0, INCR, 8'hFF, 0);
        wbuf[0] = 64'hDEADBEEF_DEADBEEF;
        exp_b(4'd1, OK);
        do_write(4'd1, 64'h0, 8'd0, INCR, 8'h0F, 0);
        drain();
        exp_r(4'd2, 64'h00000000_DEADBEEF, OK, 1);
        send_ar(4'd2, 64'h0, 8'd0, INCR);
        drain();

        // wlast on the wrong beat
        wbuf[0] = 64'h1; wbuf[1] = 64'h2;
        exp_b(4'd4, SLV);
        do_write(4'd4, 64'h50, 8'd1, INCR, 8'hFF, 1);
        drain();

        // Reserved burst type: no write, no read data
        wbuf[0] = 64'h8888_8888_8888_8888;
        exp_b(4'd4, OK);
        do_write(4'd4, 64'h40, 8'd0, INCR, 8'hFF, 0);
        wbuf[0] = 64'h9999_9999_9999_9999;
        exp_b(4'd4, SLV);
        do_write(4'd4, 64'h40, 8'd0, RSVD, 8'hFF, 0);
        drain();
        exp_r(4'd4, 64'h8888_8888_8888_8888, OK, 1);
        send_ar(4'd4, 64'h40, 8'd0, INCR);
        exp_r(4'd4, 64'h0, SLV, 1);
        send_ar(4'd4, 64'h40, 8'd0, RSVD);
        drain();

        // FIXED read with rready toggling
        wbuf[0] = 64'h5555_0000_5555_0005;
        exp_b(4'd9, OK);
        do_write(4'd9, 64'h28, 8'd0, INCR, 8'hFF, 0);
        drain();
        rd_toggle = 1;
        exp_r(4'd9, 64'h5555_0000_5555_0005, OK, 0);
        exp_r(4'd9, 64'h5555_0000_5555_0005, OK, 0);
        exp_r(4'd9, 64'h5555_0000_5555_0005, OK, 1);
        send_ar(4'd9, 64'h28, 8'd2, FIXED);
        drain();
        rd_toggle = 0;
        @(posedge clk); @(posedge clk); #1;

        // Reset in the middle of a 4-beat write
        wbuf[0] = 64'hC0; wbuf[1] = 64'hC1; wbuf[2] = 64'hC2; wbuf[3] = 64'hC3;
        exp_b(4'd10, OK);
        do_write(4'd10, 64'h60, 8'd3, INCR, 8'hFF, 0);
        drain();
        send_aw(4'd10, 64'h60, 8'd3, INCR);
        send_w(64'hD0, 8'hFF, 0);
        send_w(64'hD1, 8'hFF, 0);
        rst = 1;
        #1;
        chk("midrst_bvalid", 64'(bvalid), 0);
        chk("midrst_wready", 64'(wready), 0);
        @(negedge clk);
        rst = 0;
        @(posedge clk); #1;
        chk("midrst_awready", 64'(awready), 1);
        chk("midrst_no_b", 64'(bvalid), 0);
        exp_r(4'd11, 64'hD0, OK, 0); exp_r(4'd11, 64'hD1, OK, 0);
        exp_r(4'd11, 64'hC2, OK, 0); exp_r(4'd11, 64'hC3, OK, 1);
        send_ar(4'd11, 64'h60, 8'd3, INCR);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/axi4_burst_mem.md
# axi4_burst_mem
AXI4 memory-mapped slave responder: a word-addressed RAM behind full AXI4 write and read channels. Supports FIXED, INCR and WRAP bursts, byte strobes and ID echo. It is the burst-capable target that sits opposite the AXI4 test master. One outstanding write and one outstanding read are allowed, and the write and read channels run independently.
## Interface
- AWIDTH, 64, byte-address width
- DWIDTH, 64, data width; DBYTES=DWIDTH/8; every beat is full width (AxSIZE not implemented, fixed at log2(DBYTES))
- IDWIDTH, 4, transaction ID width
- NUM_WORDS, 24, RAM depth in DWIDTH words; legal byte addresses 0..NUM_WORDS*DBYTES-1
- clock_axi  in  1  clock, rising edge only
- reset_axi  in  1  asynchronous, active-high reset
- s_axi_awid  in  IDWIDTH  write ID
- s_axi_awaddr  in  AWIDTH  write start byte address; low log2(DBYTES) bits ignored
- s_axi_awlen  in  8  beats-1
- s_axi_awburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- s_axi_awvalid  in  1  AW valid
- s_axi_awready  out  1  AW ready
- s_axi_wdata  in  DWIDTH  write data
- s_axi_wstrb  in  DBYTES  byte enables
- s_axi_wlast  in  1  last write beat
- s_axi_wvalid  in  1  W valid
- s_axi_wready  out  1  W ready
- s_axi_bid  out  IDWIDTH  echoed AWID
- s_axi_bresp  out  2  write response
- s_axi_bvalid  out  1  B valid
- s_axi_bready  in  1  B ready
- s_axi_arid  in  IDWIDTH  read ID
- s_axi_araddr  in  AWIDTH  read start byte address
- s_axi_arlen  in  8  beats-1
- s_axi_arburst  in  2  burst type
- s_axi_arvalid  in  1  AR valid
- s_axi_arready  out  1  AR ready
- s_axi_rid  out  IDWIDTH  echoed ARID
- s_axi_rdata  out  DWIDTH  read data
- s_axi_rresp  out  2  per-beat read response
- s_axi_rlast  out  1  last read beat
- s_axi_rvalid  out  1  R valid
- s_axi_rready  in  1  R ready
## Operation
- **Write FSM**
  - W_IDLE: awready=1. On AW handshake, latch id, addr, len and burst; beat=0; go to W_DATA.
  - W_DATA: wready=1. Each W handshake writes the bytes with wstrb=1 to the current word if it is legal, then advances the address. When beat==len, go to W_RESP.
  - W_RESP: bvalid=1. Hold until bready, then go to W_IDLE.
- **Read FSM**
  - R_IDLE: arready=1. On AR handshake, latch fields and load beat 0 into rdata; go to R_DATA.
  - R_DATA: rvalid=1, rlast=(beat==len). Each R handshake loads the next beat. The handshake on the last beat returns to R_IDLE.
- **Address generation** (word = addr>>log2(DBYTES)):
  - FIXED: word constant for the whole burst.
  - INCR: +1 word per beat.
  - WRAP: len must be 1/3/7/15. Wraps within the (len+1)-word aligned block containing the start word. Any other len gives SLVERR on every beat.
- **Errors**
  - Word>=NUM_WORDS: write suppressed, rdata=0, rresp=SLVERR for that beat.
  - Reserved burst type: no access on any beat, all beats SLVERR.
  - bresp=SLVERR if any beat errored or any wlast!=(beat==len); otherwise OKAY.
  - EXOKAY is never returned. 4KB crossing is not checked.
## Timing
- **Reset**
  - All valid/ready outputs, rlast, bresp, rresp, bid, rid and rdata are 0.
  - RAM contents are not reset.
  - First rising edge after deassertion: awready=arready=1.
- **Reset mid-burst:** FSMs abort to idle and no response is issued. Beats already written stay written.
- **Write latency**
  - AW handshake at edge N: wready=1 from N+1. wready=0 in W_IDLE, so early W beats wait.
  - Last W beat at edge M: bvalid=1 from M+1.
- **Read latency**
  - AR handshake at edge N: rvalid=1 with beat 0 from N+1.
  - Sustained 1 beat/cycle with rready and wvalid held high; no bubbles.
- **Stability:** outputs are held stable while valid=1 and ready=0.
- **Write and read to the same word on the same edge:** the read returns the pre-write value.
## Configuration
- AXI4_BURST_MEM_WRAP_EN
  - Defined: WRAP bursts are supported as above.
  - Undefined: burst type 10 is treated as reserved (no access, SLVERR).
## Structure
- **Package axi4_burst_pkg** holds:
  - burst type constants FIXED/INCR/WRAP
  - response constants OKAY/EXOKAY/SLVERR/DECERR
  - write and read FSM state typedefs
- **Sub-module axi4_burst_addr_gen:** combinational next-word and legality from (current word, start word, burst, len). Instantiated once per channel.
## Test plan
- INCR write, id=3, awlen=3, addr 0x0, data 0x11..0x44, wstrb=FF; then INCR read of 4 beats -> bid=3, bresp=OKAY; rdata 0x11,0x22,0x33,0x44; rlast only on beat 3; rid echoes ARID.
- WRAP read, arlen=3, addr 0x10 (word 2), words 0..3 preloaded -> order word2, word3, word0, word1. With the macro undefined -> 4 beats of SLVERR, rdata=0.
- Write addr 0xB8 (word 23) INCR len=1 -> word 23 written, word 24 suppressed, bresp=SLVERR. Single write to word 0 with wstrb=0x0F of 0xDEADBEEF_DEADBEEF over 0 -> word 0 reads 0x00000000_DEADBEEF.
- Read with rready toggling 1/0 every cycle, FIXED len=2 on word 5 -> rdata/rlast held during stalls; 3 identical beats, rlast on the third.
- Assert reset_axi in the middle of a 4-beat write after beat 1 -> no bvalid; awready=1 on the first edge after release; beats 0-1 present in RAM, beats 2-3 unchanged.
